pb_level_ctrl: RTL and testbench
================================

# pb_level_ctrl

Pushbutton front end for the bargraph/decoder display path. It synchronizes and debounces the raw `pb` bus and turns button presses into a held 4-bit level and 3-bit selector. The level is presented one-hot so the downstream bargraph stage expands it into a thermometer on `left`/`right`. The selector drives the downstream 3-to-8 decoder for the segment decimal points.

## Interface
- `DEBOUNCE_CYCLES`, default 2: consecutive stable post-sync samples required before a `pb` change is accepted; legal range 1–15.
- `hz100` in 1: system clock, 100 Hz.
- `reset` in 1: asynchronous, active-low reset. Asserting it (driving low) clears all state immediately.
- `pb` in 21: raw pushbuttons; asynchronous and bouncy.
- `level_onehot` out 16: `1 << level` when `active`, else 16'h0000; feeds bargraph `in`.
- `sel` out 3: selector; feeds decoder `in2`.
- `active` out 1: high once a level has been set.
- `changed` out 1: one-cycle pulse on any cycle where `level`, `sel` or `active` changed.

## Operation
- **Sync:** two flops, `s1` then `s2`, on all 21 bits.
- **Debounce:** one shared candidate register `cand[20:0]` and a counter `cnt`.
  - If `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= cand`, and `cnt` holds.
  - Else: `cnt <= cnt+1`.
- **Edge detect:** `db_q <= db`; `rise = db & ~db_q` (combinational).
- **Internal state:** `level[3:0]`, `sel[2:0]`, `active`.
- **Command priority, evaluated each cycle from `rise`:**
  1. `rise[19]` (clear): `level=0`, `sel=0`, `active=0`. All other commands are ignored that cycle.
  2. Any `rise[15:0]` (direct set): `level` = index of the highest set bit of `rise[15:0]`; `active=1`. Up/down are ignored that cycle.
  3. Up/down:
     - `rise[16]` alone: if `!active`, then `active=1` and `level=0`; else `level=min(level+1,15)`.
     - `rise[17]` alone: if `active`, `level=max(level-1,0)`; if `!active`, no change.
     - Both `rise[16]` and `rise[17]`: no change.
- **Selector:** `rise[18]` sets `sel=sel+1` mod 8 (7 wraps to 0). It applies together with priority 2/3 but not with clear.
- **Ignored inputs:** `pb[20]`; button releases (falling edges).
- **`changed`:** registered; high for the cycle after any update whose new value differs from the old one. Saturated up/down, i.e. no value change, gives no pulse.

## Timing
- **Reset values:** `s1`, `s2`, `cand`, `db`, `db_q` = 0; `cnt`=0; `level`=0; `sel`=0; `active`=0. So `level_onehot`=16'h0000, `sel`=3'd0, `changed`=0.
- **All outputs are registered;** none is combinational from `pb`.
- **Latency:** `pb` is held stable from before clock edge E1. Then:
  - `s1` at E1, `s2` at E2, `cand` at E3.
  - `db` at E(3+DEBOUNCE_CYCLES).
  - Outputs update at E(4+DEBOUNCE_CYCLES): E6 = 60 ms for the default.
  - `changed` is high for the cycle after that edge.
- **Glitch rejection:** a `pb` change that reverts before `db` updates never reaches `db` and produces no command. Minimum accepted pulse is DEBOUNCE_CYCLES+1 samples wide at `s2`.
- **Held buttons:** a button held indefinitely produces exactly one command; there is no auto-repeat.
- **Release and re-press:** each re-press needs the full latency again.
- **Reset mid-operation:** an in-flight debounce is discarded. A button still held after reset deasserts is accepted as a new press, since `db` restarts at 0.
- **Accepted-set changes:** if several buttons change within the debounce window, they are accepted together as one `db` update. Priority rules then apply to that single cycle.

## Test plan
- **Reset:** assert `reset` low mid-run with `pb[5]` held → `level_onehot`=0, `sel`=0, `active`=0 immediately. Release reset → `level_onehot`=16'h0020 at edge 6 after release.
- **Direct set priority:** press `pb[3]` and `pb[12]` together, default parameter → `level_onehot`=16'h1000 at edge 6, `changed` high one cycle. A later press of `pb[3]` alone → 16'h0008.
- **Up/down saturation:**
  - From inactive, `pb[17]` → no change, no `changed`.
  - `pb[16]` → 16'h0001.
  - From level 15, `pb[16]` → stays 16'h8000, `changed`=0.
  - From level 0, `pb[17]` → stays 16'h0001.
  - `pb[16]` and `pb[17]` pressed together → no change.
- **Selector wrap:** eight `pb[18]` presses → `sel` steps 1..7, then 0. `pb[18]` together with `pb[19]` → `sel`=0, `level_onehot`=0.
- **Debounce:**
  - `pb[7]` high for 2 samples then low → no change.
  - `pb[7]` bouncing 1,0,1,1,1,… → exactly one command, `level_onehot`=16'h0080, with latency counted from the last bounce.
  - Holding `pb[7]` for 100 cycles → a single `changed` pulse.
- **Parameter:** `DEBOUNCE_CYCLES`=1 → outputs update at edge 5. `DEBOUNCE_CYCLES`=4 → outputs update at edge 8.

Source files
------------

// File: rtl/pb_level_ctrl.sv
// Pushbutton front end: syncs and debounces the pb bus, then turns accepted presses
// into a held level (presented one-hot), a 3-bit selector and an activity flag.
module pb_level_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [20:0] pb,
    output logic [15:0] level_onehot,
    output logic [2:0]  sel,
    output logic        active,
    output logic        changed
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CYCLES - 1);

    logic [20:0] s1, s2, cand, db, db_q;
    logic [3:0]  cnt;
    logic [20:0] rise;
    logic        unused_rise20;

    // One shared candidate: any change on any bit restarts the stability window.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            db   <= '0;
            db_q <= '0;
        end else begin
            s1   <= pb;
            s2   <= s1;
            db_q <= db;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                db   <= cand;
            end else begin
                cnt  <= cnt + 4'd1;
            end
        end
    end

    assign rise          = db & ~db_q;
    assign unused_rise20 = rise[20];

    logic [3:0] level, nxt_level, hi;
    logic [2:0] nxt_sel;
    logic       nxt_active;

    always_comb begin
        hi = '0;
        for (int i = 0; i < 16; i++)
            if (rise[i]) hi = 4'(i);
    end

    always_comb begin
        nxt_level  = level;
        nxt_sel    = sel;
        nxt_active = active;
        if (rise[19]) begin
            nxt_level  = '0;
            nxt_sel    = '0;
            nxt_active = 1'b0;
        end else begin
            if (|rise[15:0]) begin
                nxt_level  = hi;
                nxt_active = 1'b1;
            end else if (rise[16] && !rise[17]) begin
                if (!active) begin
                    nxt_active = 1'b1;
                    nxt_level  = '0;
                end else if (level != 4'd15) begin
                    nxt_level  = level + 4'd1;
                end
            end else if (rise[17] && !rise[16]) begin
                if (active && level != 4'd0)
                    nxt_level = level - 4'd1;
            end
            if (rise[18])
                nxt_sel = sel + 3'd1;
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            level        <= '0;
            sel          <= '0;
            active       <= 1'b0;
            level_onehot <= '0;
            changed      <= 1'b0;
        end else begin
            level        <= nxt_level;
            sel          <= nxt_sel;
            active       <= nxt_active;
            level_onehot <= nxt_active ? (16'h0001 << nxt_level) : 16'h0000;
            changed      <= (nxt_level != level) || (nxt_sel != sel) || (nxt_active != active);
        end
    end

endmodule

// File: tb/tb_pb_level_ctrl.sv
// Directed bench for pb_level_ctrl; three instances share pb/reset to cover
// DEBOUNCE_CYCLES = 2 (main), 1 and 4.
module tb_pb_level_ctrl;

    logic        hz100 = 1'b0;
    logic        reset = 1'b0;
    logic [20:0] pb    = '0;

    logic [15:0] oh, oh1, oh4;
    logic [2:0]  sel, sel1, sel4;
    logic        act, act1, act4;
    logic        chg, chg1, chg4;

    int checks = 0;
    int failures = 0;

    always #5 hz100 = ~hz100;

    pb_level_ctrl #(.DEBOUNCE_CYCLES(2)) dut (
        .hz100(hz100), .reset(reset), .pb(pb),
        .level_onehot(oh), .sel(sel), .active(act), .changed(chg));
    pb_level_ctrl #(.DEBOUNCE_CYCLES(1)) dut1 (
        .hz100(hz100), .reset(reset), .pb(pb),
        .level_onehot(oh1), .sel(sel1), .active(act1), .changed(chg1));
    pb_level_ctrl #(.DEBOUNCE_CYCLES(4)) dut4 (
        .hz100(hz100), .reset(reset), .pb(pb),
        .level_onehot(oh4), .sel(sel4), .active(act4), .changed(chg4));

    task automatic step(input int n);
        repeat (n) @(posedge hz100);
        #1;
    endtask

    // Hold a pattern long enough for every instance to accept it, then release and settle.
    task automatic press(input logic [20:0] v);
        pb = v;
        step(8);
        pb = '0;
        step(8);
    endtask

    task automatic test_reset;
        step(2);
        checks++;
        if ({oh, sel, act, chg} !== 23'd0) begin
            failures++; $display("FAIL reset_state got=%h exp=0", {oh, sel, act, chg});
        end
        reset = 1'b1;
        step(10);
        checks++;
        if ({oh, sel, act, chg} !== 23'd0) begin
            failures++; $display("FAIL idle_after_reset got=%h exp=0", {oh, sel, act, chg});
        end
        pb = 21'd1 << 5;
        step(5);
        checks++;
        if (oh !== 16'h0000) begin
            failures++; $display("FAIL pb5_early oh=%h exp=0000", oh);
        end
        step(1);
        checks++;
        if (oh !== 16'h0020 || chg !== 1'b1 || act !== 1'b1) begin
            failures++; $display("FAIL pb5_e6 oh=%h chg=%b act=%b exp 0020/1/1", oh, chg, act);
        end
        step(3);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({oh, sel, act, chg} !== 23'd0) begin
            failures++; $display("FAIL async_reset got=%h exp=0", {oh, sel, act, chg});
        end
        step(2);
        reset = 1'b1;
        step(5);
        checks++;
        if (oh !== 16'h0000) begin
            failures++; $display("FAIL held_after_reset_e5 oh=%h exp=0000", oh);
        end
        step(1);
        checks++;
        if (oh !== 16'h0020 || chg !== 1'b1) begin
            failures++; $display("FAIL held_after_reset_e6 oh=%h chg=%b exp 0020/1", oh, chg);
        end
        pb = '0;
        step(8);
    endtask

    task automatic test_direct;
        pb = (21'd1 << 3) | (21'd1 << 12);
        step(5);
        checks++;
        if (oh !== 16'h0020 || chg !== 1'b0) begin
            failures++; $display("FAIL direct_e5 oh=%h chg=%b exp 0020/0", oh, chg);
        end
        step(1);
        checks++;
        if (oh !== 16'h1000 || chg !== 1'b1) begin
            failures++; $display("FAIL direct_hi oh=%h chg=%b exp 1000/1", oh, chg);
        end
        step(1);
        checks++;
        if (chg !== 1'b0) begin
            failures++; $display("FAIL direct_pulse_len chg=%b exp 0", chg);
        end
        pb = '0;
        step(8);
        pb = 21'd1 << 3;
        step(6);
        checks++;
        if (oh !== 16'h0008) begin
            failures++; $display("FAIL direct_pb3 oh=%h exp 0008", oh);
        end
        pb = '0;
        step(8);
    endtask

    task automatic test_updown;
        press(21'd1 << 19);
        checks++;
        if ({oh, sel, act} !== 20'd0) begin
            failures++; $display("FAIL clear got=%h exp 0", {oh, sel, act});
        end
        pb = 21'd1 << 17;
        step(6);
        checks++;
        if (oh !== 16'h0000 || act !== 1'b0 || chg !== 1'b0) begin
            failures++; $display("FAIL down_inactive oh=%h act=%b chg=%b exp 0000/0/0", oh, act, chg);
        end
        pb = '0;
        step(8);
        pb = 21'd1 << 16;
        step(6);
        checks++;
        if (oh !== 16'h0001 || act !== 1'b1 || chg !== 1'b1) begin
            failures++; $display("FAIL up_activate oh=%h act=%b chg=%b exp 0001/1/1", oh, act, chg);
        end
        pb = '0;
        step(8);
        press(21'd1 << 15);
        pb = 21'd1 << 16;
        step(6);
        checks++;
        if (oh !== 16'h8000 || chg !== 1'b0) begin
            failures++; $display("FAIL up_sat oh=%h chg=%b exp 8000/0", oh, chg);
        end
        pb = '0;
        step(8);
        press(21'd1 << 0);
        pb = 21'd1 << 17;
        step(6);
        checks++;
        if (oh !== 16'h0001 || chg !== 1'b0) begin
            failures++; $display("FAIL down_sat oh=%h chg=%b exp 0001/0", oh, chg);
        end
        pb = '0;
        step(8);
        press(21'd1 << 3);
        pb = (21'd1 << 16) | (21'd1 << 17);
        step(6);
        checks++;
        if (oh !== 16'h0008 || chg !== 1'b0) begin
            failures++; $display("FAIL up_down_both oh=%h chg=%b exp 0008/0", oh, chg);
        end
        pb = '0;
        step(8);
        press(21'd1 << 17);
        checks++;
        if (oh !== 16'h0004) begin
            failures++; $display("FAIL down_step oh=%h exp 0004", oh);
        end
    endtask

    task automatic test_sel_wrap;
        for (int i = 1; i <= 8; i++) begin
            pb = 21'd1 << 18;
            step(6);
            checks++;
            if (sel !== 3'(i % 8) || chg !== 1'b1 || oh !== 16'h0004) begin
                failures++;
                $display("FAIL sel_step%0d sel=%0d chg=%b oh=%h exp %0d/1/0004", i, sel, chg, oh, i % 8);
            end
            pb = '0;
            step(8);
        end
        press(21'd1 << 18);
        press((21'd1 << 18) | (21'd1 << 19));
        checks++;
        if (sel !== 3'd0 || oh !== 16'h0000 || act !== 1'b0) begin
            failures++; $display("FAIL sel_clear sel=%0d oh=%h act=%b exp 0/0000/0", sel, oh, act);
        end
    endtask

    task automatic test_debounce;
        int pulses;
        pulses = 0;
        pb = 21'd1 << 7;
        step(2);
        pb = '0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            pulses += int'(chg);
        end
        checks++;
        if (oh !== 16'h0000 || act !== 1'b0 || pulses != 0) begin
            failures++; $display("FAIL glitch oh=%h act=%b pulses=%0d exp 0000/0/0", oh, act, pulses);
        end
        pb = 21'd1 << 7;
        step(1);
        pb = '0;
        step(1);
        pb = 21'd1 << 7;
        step(5);
        checks++;
        if (oh !== 16'h0000) begin
            failures++; $display("FAIL bounce_e5 oh=%h exp 0000", oh);
        end
        step(1);
        checks++;
        if (oh !== 16'h0080 || chg !== 1'b1) begin
            failures++; $display("FAIL bounce_e6 oh=%h chg=%b exp 0080/1", oh, chg);
        end
        pulses = 1;
        for (int i = 0; i < 98; i++) begin
            step(1);
            pulses += int'(chg);
        end
        checks++;
        if (pulses != 1 || oh !== 16'h0080) begin
            failures++; $display("FAIL hold_100 pulses=%0d oh=%h exp 1/0080", pulses, oh);
        end
        pb = '0;
        step(8);
    endtask

    task automatic test_param;
        press(21'd1 << 19);
        pb = 21'd1 << 9;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            checks++;
            if (oh1 !== ((e >= 5) ? 16'h0200 : 16'h0000) || chg1 !== (e == 5)) begin
                failures++; $display("FAIL d1_edge%0d oh=%h chg=%b", e, oh1, chg1);
            end
            checks++;
            if (oh !== ((e >= 6) ? 16'h0200 : 16'h0000)) begin
                failures++; $display("FAIL d2_edge%0d oh=%h", e, oh);
            end
            checks++;
            if (oh4 !== ((e >= 8) ? 16'h0200 : 16'h0000) || chg4 !== (e == 8)) begin
                failures++; $display("FAIL d4_edge%0d oh=%h chg=%b", e, oh4, chg4);
            end
        end
        pb = '0;
        step(8);
    endtask

    initial begin
        test_reset;
        test_direct;
        test_updown;
        test_sel_wrap;
        test_debounce;
        test_param;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
